// File: rtl/cp0.sv
`default_nettype none
// ============================================================================
//  Module      : cp0
//  Description : MIPS system control coprocessor. Holds SR, Cause, EPC and
//                PRId, merges six hardware interrupt lines with the
//                pipeline's synchronous exception code, raises the
//                exception/interrupt request and records the victim context.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0 #(
    parameter logic [31:0] PRID = 32'h0000_4D49
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    // ------------------------------------------------------------------
    // Register numbers
    // ------------------------------------------------------------------
    localparam logic [4:0] c_REG_SR    = 5'd12;
    localparam logic [4:0] c_REG_CAUSE = 5'd13;
    localparam logic [4:0] c_REG_EPC   = 5'd14;
    localparam logic [4:0] c_REG_PRID  = 5'd15;

    // ------------------------------------------------------------------
    // State: only the architecturally meaningful bits are stored
    // ------------------------------------------------------------------
    logic [5:0]  r_im_q,      r_im_d;       // SR[15:10]
    logic        r_exl_q,     r_exl_d;      // SR[1]
    logic        r_ie_q,      r_ie_d;       // SR[0]
    logic        r_bd_q,      r_bd_d;       // Cause[31]
    logic [5:0]  r_ip_q,      r_ip_d;       // Cause[15:10]
    logic [4:0]  r_exccode_q, r_exccode_d;  // Cause[6:2]
    logic [31:0] r_epc_q,     r_epc_d;

    logic        w_int_pend;
    logic        w_exc_pend;
    logic        w_entry;
    logic        w_wr_sr;
    logic        w_wr_epc;
    logic [31:0] w_victim_pc;

    // Only SR[15:10], SR[1:0] and full EPC are writable; the rest of DIn
    // is intentionally dropped.
    logic        w_unused_din;
    assign w_unused_din = &{1'b0, DIn[31:16], DIn[9:2]};

    // Request decode: interrupts use the live lines since timer IRQs are
    // single-cycle pulses and would be missed if only the IP copy were used.
    always_comb begin
        w_int_pend = (|(HWInt & r_im_q)) & r_ie_q & ~r_exl_q;
        w_exc_pend = (ExcCodeIn != 5'd0) & ~r_exl_q;
        w_entry    = w_int_pend | w_exc_pend;
        IntReq     = w_entry;
    end

    // mtc0 write strobes and victim address (delay-slot victims restart at
    // the branch; subtraction wraps modulo 2^32)
    always_comb begin
        w_wr_sr     = WE && (A == c_REG_SR);
        w_wr_epc    = WE && (A == c_REG_EPC);
        w_victim_pc = (BDIn ? (PC - 32'd4) : PC) & ~32'd3;
    end

    // Next-state for SR: entry beats mtc0, entry beats eret, eret beats
    // an mtc0 write to EXL
    always_comb begin
        r_im_d  = r_im_q;
        r_ie_d  = r_ie_q;
        r_exl_d = r_exl_q;
        if (w_entry) begin
            r_exl_d = 1'b1;
        end else begin
            if (w_wr_sr) begin
                r_im_d  = DIn[15:10];
                r_ie_d  = DIn[0];
                r_exl_d = DIn[1];
            end
            if (EXLClr) begin
                r_exl_d = 1'b0;
            end
        end
    end

    // Next-state for Cause and EPC: IP samples the lines every cycle, the
    // rest only changes on entry (Cause is read-only to mtc0)
    always_comb begin
        r_ip_d      = HWInt;
        r_bd_d      = r_bd_q;
        r_exccode_d = r_exccode_q;
        r_epc_d     = r_epc_q;
        if (w_entry) begin
            r_bd_d      = BDIn;
            r_exccode_d = w_int_pend ? 5'd0 : ExcCodeIn;
            r_epc_d     = w_victim_pc;
        end else if (w_wr_epc) begin
            r_epc_d     = DIn;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_im_q      <= 6'd0;
            r_exl_q     <= 1'b0;
            r_ie_q      <= 1'b0;
            r_bd_q      <= 1'b0;
            r_ip_q      <= 6'd0;
            r_exccode_q <= 5'd0;
            r_epc_q     <= 32'd0;
        end else begin
            r_im_q      <= r_im_d;
            r_exl_q     <= r_exl_d;
            r_ie_q      <= r_ie_d;
            r_bd_q      <= r_bd_d;
            r_ip_q      <= r_ip_d;
            r_exccode_q <= r_exccode_d;
            r_epc_q     <= r_epc_d;
        end
    end

    // mfc0 read mux, no read latency
    always_comb begin
        DOut = 32'd0;
        case (A)
            c_REG_SR:    DOut = {16'd0, r_im_q, 8'd0, r_exl_q, r_ie_q};
            c_REG_CAUSE: DOut = {r_bd_q, 15'd0, r_ip_q, 3'd0, r_exccode_q, 2'd0};
            c_REG_EPC:   DOut = r_epc_q;
            c_REG_PRID:  DOut = PRID;
            default:     DOut = 32'd0;
        endcase
    end

    assign EPC = r_epc_q;

endmodule
`default_nettype wire

// File: tb/tb_cp0.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0
//  Description : Directed self-checking bench for cp0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0;

    logic        clk;
    logic        reset;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    int r_checks   = 0;
    int r_failures = 0;

    cp0 #(.PRID(32'h0000_4D49)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .DIn       (DIn),
        .WE        (WE),
        .PC        (PC),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .IntReq    (IntReq),
        .EPC       (EPC),
        .DOut      (DOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // advance one clock edge, then settle 1ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        WE = 1'b0; DIn = 32'd0; EXLClr = 1'b0; HWInt = 6'd0;
        ExcCodeIn = 5'd0; BDIn = 1'b0; PC = 32'd0;
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] val);
        A = addr;
        #1;
        val = DOut;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        A = addr; DIn = data; WE = 1'b1;
        step();
        WE = 1'b0; DIn = 32'd0;
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b1; A = 5'd0;
        idle();
        step(); step();
        reset = 1'b0;
        #1;
        // reset state
        chk("rst_intreq", {31'd0, IntReq}, 32'd0);
        rd(5'd12, v); chk("rst_sr", v, 32'd0);
        rd(5'd13, v); chk("rst_cause", v, 32'd0);
        rd(5'd14, v); chk("rst_epc_reg", v, 32'd0);
        rd(5'd15, v); chk("rst_prid", v, 32'h0000_4D49);
        chk("rst_epc_port", EPC, 32'd0);
        rd(5'd3, v);  chk("unused_reg", v, 32'd0);

        // interrupt entry
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, v); chk("sr_written", v, 32'h0000_0401);
        HWInt = 6'b000001; PC = 32'h3010; #1;
        chk("int_req", {31'd0, IntReq}, 32'd1);
        step(); idle(); #1;
        chk("int_req_drop", {31'd0, IntReq}, 32'd0);
        chk("int_epc", EPC, 32'h3010);
        rd(5'd12, v); chk("int_sr_exl", v, 32'h0000_0403);
        rd(5'd13, v); chk("int_cause", v, 32'h0000_0400);

        // eret, then interrupt in delay slot
        EXLClr = 1'b1; step(); idle();
        rd(5'd12, v); chk("eret_sr", v, 32'h0000_0401);
        HWInt = 6'b000001; BDIn = 1'b1; PC = 32'h3014; #1;
        chk("bd_int_req", {31'd0, IntReq}, 32'd1);
        step(); idle(); #1;
        chk("bd_epc", EPC, 32'h3010);
        rd(5'd13, v); chk("bd_cause", v, 32'h8000_0400);
        HWInt = 6'b000001; PC = 32'h5000; #1;
        chk("exl_masks_int", {31'd0, IntReq}, 32'd0);
        step(); idle(); #1;
        chk("exl_epc_kept", EPC, 32'h3010);

        // interrupt beats synchronous exception
        EXLClr = 1'b1; step(); idle();
        ExcCodeIn = 5'd4; HWInt = 6'b000001; PC = 32'h2000; #1;
        chk("prio_req", {31'd0, IntReq}, 32'd1);
        step(); idle();
        rd(5'd13, v); chk("prio_cause", v, 32'h0000_0400);
        chk("prio_epc", EPC, 32'h2000);

        // eret beats mtc0 EXL
        A = 5'd12; DIn = 32'h0000_0403; WE = 1'b1; EXLClr = 1'b1;
        step(); idle();
        rd(5'd12, v); chk("eret_vs_mtc0", v, 32'h0000_0401);

        // exception with IM=0
        mtc0(5'd12, 32'h0000_0001);
        rd(5'd12, v); chk("sr_im0", v, 32'h0000_0001);
        ExcCodeIn = 5'd4; HWInt = 6'b000001; PC = 32'h2468; #1;
        chk("exc_req", {31'd0, IntReq}, 32'd1);
        step(); idle();
        rd(5'd13, v); chk("exc_cause", v, 32'h0000_0410);
        chk("exc_epc", EPC, 32'h2468);

        // Cause read-only (IP resamples to 0)
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, v); chk("cause_ro", v, 32'h0000_0010);

        // EPC writable
        mtc0(5'd14, 32'h1234_5677);
        rd(5'd14, v); chk("epc_mtc0", v, 32'h1234_5677);

        // entry beats mtc0 EPC; PC-4 wraps
        EXLClr = 1'b1; step(); idle();
        A = 5'd14; DIn = 32'hAAAA_AAAA; WE = 1'b1;
        ExcCodeIn = 5'd5; BDIn = 1'b1; PC = 32'h0000_0002; #1;
        chk("wrap_req", {31'd0, IntReq}, 32'd1);
        step(); idle();
        chk("wrap_epc", EPC, 32'hFFFF_FFFC);
        rd(5'd13, v); chk("wrap_cause", v, 32'h8000_0014);
        rd(5'd12, v); chk("wrap_sr", v, 32'h0000_0003);

        // interrupt then reset
        EXLClr = 1'b1; step(); idle();
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001; PC = 32'h3000; #1;
        chk("pre_rst_req", {31'd0, IntReq}, 32'd1);
        step(); idle();
        reset = 1'b1; step(); reset = 1'b0;
        rd(5'd12, v); chk("mid_rst_sr", v, 32'd0);
        rd(5'd13, v); chk("mid_rst_cause", v, 32'd0);
        rd(5'd14, v); chk("mid_rst_epc", v, 32'd0);
        chk("mid_rst_req", {31'd0, IntReq}, 32'd0);

        // exception still requested with IE=0
        ExcCodeIn = 5'd1; #1;
        chk("exc_ie0_req", {31'd0, IntReq}, 32'd1);
        idle(); #1;

        $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0.md
# cp0

System control coprocessor for the MIPS core: holds SR, Cause, EPC and PRId, and collects the six hardware interrupt lines. Timer and other device `IRQ_O` outputs feed these lines directly. The block raises the interrupt request to the pipeline, records exception context on entry, and clears EXL on `eret`. It sits beside the M stage, downstream of the timers' interrupt outputs and of the pipeline's `mfc0`/`mtc0`/exception signals.

## Interface
- `PRID`, default 32'h0000_4D49, constant value returned for register 15.
- `clk`  in  1  system clock; all state updates on the posedge.
- `reset`  in  1  synchronous, active-high; clears all state on the posedge where it is high.
- `A`  in  5  CP0 register number for read (`mfc0`) and write (`mtc0`).
- `DIn`  in  32  `mtc0` write data.
- `WE`  in  1  `mtc0` write enable.
- `PC`  in  32  PC of the instruction in M stage (victim instruction).
- `BDIn`  in  1  victim instruction is in a branch delay slot.
- `ExcCodeIn`  in  5  synchronous exception code from the pipeline; 0 means none.
- `HWInt`  in  6  device interrupt lines. Bit 0 is timer0 `IRQ_O`, bit 1 is timer1 `IRQ_O`, bits 2..5 are other devices.
- `EXLClr`  in  1  `eret` in M stage.
- `IntReq`  out  1  take exception or interrupt this cycle; pipeline flushes and redirects to 0x0000_4180.
- `EPC`  out  32  current EPC register, used as the `eret` target.
- `DOut`  out  32  read data for register `A`.

## Operation
- SR (reg 12): IM = SR[15:10], EXL = SR[1], IE = SR[0]. All other bits read 0 and ignore writes.
- Cause (reg 13): BD = Cause[31], IP = Cause[15:10], ExcCode = Cause[6:2]. All other bits read 0. Cause is read-only to `mtc0`.
- EPC (reg 14): full 32 bits, writable by `mtc0`. On exception entry the low 2 bits are forced to 0.
- PRId (reg 15): returns `PRID`.
- Any other `A` reads 0. Writes to any other `A` are ignored.
- Interrupt condition: `IntPend = |(HWInt & IM) & IE & !EXL`. This uses the live `HWInt` because timer IRQ lines are one-cycle pulses.
- Exception condition: `ExcPend = (ExcCodeIn != 0) & !EXL`.
- `IntReq = IntPend | ExcPend`. It is combinational from the inputs and the current registers.
- Entry (posedge with `IntReq`=1):
  - EXL ← 1.
  - BD ← `BDIn`.
  - EPC ← (`BDIn` ? `PC`-4 : `PC`) & ~3.
  - ExcCode ← 0 if `IntPend`, else `ExcCodeIn`. Interrupts have priority over synchronous exceptions.
- IP ← `HWInt` on every posedge. IP is a sampled level and is not sticky.
- `EXLClr` clears EXL on the posedge.
- Simultaneous events:
  - Entry beats `mtc0`: a write in the same cycle is discarded for SR and EPC.
  - Entry beats `EXLClr`.
  - `EXLClr` beats an `mtc0` write to SR bit 1.
- Arithmetic: `PC`-4 is modulo 2^32.

## Timing
- Reset: SR=0, Cause=0, EPC=0.
  - After reset, `IntReq`=0 because IE=0. It stays 0 until the first non-zero `ExcCodeIn`.
  - `EPC`=0 and `DOut` reflects zeroed registers.
- `mtc0` takes effect at the posedge; `DOut` shows the new value in the following cycle.
- `DOut` is combinational on `A` and the current registers. There is no read latency.
- Reading Cause shows IP one cycle behind `HWInt`.
- Exception entry updates EXL, EPC and Cause at the same posedge. `IntReq` drops in the next cycle because EXL=1.
- A `HWInt` pulse arriving while EXL=1 or IE=0 is not latched and is lost. Software must reenable the timer or poll its CTRL.
- Reset asserted mid-exception clears EXL and EPC at that posedge.

## Test plan
- Reset, then read regs 12/13/14/15: expect 0, 0, 0, 0x0000_4D49; `IntReq`=0 throughout.
- `mtc0` SR=0x0000_0401 (IM[0], IE); pulse `HWInt`=6'b000001 for one cycle with `PC`=0x3010: `IntReq`=1 that cycle. Next cycle: EPC=0x3010, SR reads 0x403, Cause ExcCode=0, IP[0] reads 1.
- Same setup with `BDIn`=1 and `PC`=0x3014 on the pulse: EPC=0x3010, Cause[31]=1. A second `HWInt` pulse while EXL=1 gives `IntReq`=0.
- SR=0x0000_0401; `ExcCodeIn`=4 and `HWInt`=1 in the same cycle: ExcCode recorded as 0. Repeat with SR IM=0: ExcCode recorded as 4, EPC=`PC`.
- With EXL=1, assert `EXLClr` and `mtc0` SR=0x403 in the same cycle: SR reads 0x401. `mtc0` Cause=0xFFFF_FFFF: Cause unchanged.
- Take an interrupt, then assert `reset` the next cycle: SR, Cause and EPC all read 0 and `IntReq`=0.
